// File: rtl/req_onehot_rr_arbiter_if.sv
// Request/grant bundle for req_onehot_rr_arbiter.
// slave  : arbiter side (consumes req/gnt_ready, drives grant and status)
// master : requester/consumer side
interface req_onehot_rr_arbiter_if #(
  parameter int N = 8
);
  logic [N-1:0] req;
  logic         gnt_ready;
  logic         gnt_valid;
  logic [N-1:0] gnt_onehot;
  logic [N-1:0] pending;

  modport slave (
    input  req,
    input  gnt_ready,
    output gnt_valid,
    output gnt_onehot,
    output pending
  );

  modport master (
    output req,
    output gnt_ready,
    input  gnt_valid,
    input  gnt_onehot,
    input  pending
  );
endinterface

// File: rtl/req_onehot_rr_arbiter.sv
// req_onehot_rr_arbiter
// Captures request lines into sticky pending bits and hands them out one at a
// time, round-robin, as a strictly one-hot grant with a valid/ready handshake.
// Optional build macro: REQ_EDGE_DETECT_EN
//   defined   : a request pends once per rising edge of its req line
//   undefined : a request pends every cycle its req line is high (level)
module req_onehot_rr_arbiter #(
  parameter int N     = 8,
  parameter int PTR_W = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  req_onehot_rr_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_r;
  logic [N-1:0]       pending_r;
  logic [N-1:0]       gnt_onehot_r;
  logic               gnt_valid_r;
  logic [PTR_W-1:0]   ptr_r;
  logic [PTR_W-1:0]   gnt_idx_r;

  logic [N-1:0]       set_s;
  logic [N-1:0]       clr_s;
  logic [N-1:0]       pending_nxt_s;
  logic               accept_s;
  logic               pick_any_s;
  logic [PTR_W-1:0]   pick_idx_s;
  logic [PTR_W:0]     cand_s;

  // Decode an index into a single-bit vector; the only source of gnt_onehot.
  function automatic logic [N-1:0] onehot_f(input logic [PTR_W-1:0] idx);
    logic [N-1:0] v;
    v = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (idx == PTR_W'(i)) begin
        v[i] = 1'b1;
      end else begin
        v[i] = 1'b0;
      end
    end
    return v;
  endfunction

`ifdef REQ_EDGE_DETECT_EN
  logic [N-1:0] req_q_r;

  // Previous req sample, used to turn held lines into single rising-edge events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q_r <= {N{1'b0}};
    end else begin
      req_q_r <= bus.req;
    end
  end

  assign set_s = bus.req & ~req_q_r;
`else
  assign set_s = bus.req;
`endif

  assign accept_s      = gnt_valid_r & bus.gnt_ready;
  assign clr_s         = accept_s ? gnt_onehot_r : {N{1'b0}};
  // A new request on the line being accepted wins, so it is not lost.
  assign pending_nxt_s = set_s | (pending_r & ~clr_s);

  // Round-robin search: first pending bit at ptr, ptr+1, ..., wrapping at N.
  always_comb begin
    pick_any_s = 1'b0;
    pick_idx_s = {PTR_W{1'b0}};
    cand_s     = {(PTR_W+1){1'b0}};
    for (int i = 0; i < N; i++) begin
      cand_s = {1'b0, ptr_r} + (PTR_W+1)'(i);
      if (cand_s >= (PTR_W+1)'(N)) begin
        cand_s = cand_s - (PTR_W+1)'(N);
      end else begin
        cand_s = cand_s;
      end
      if (!pick_any_s && pending_r[cand_s[PTR_W-1:0]]) begin
        pick_any_s = 1'b1;
        pick_idx_s = cand_s[PTR_W-1:0];
      end else begin
        pick_any_s = pick_any_s;
      end
    end
  end

  // Sticky pending bits, updated every cycle regardless of FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= {N{1'b0}};
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  // Grant FSM: issue one grant from IDLE, hold it in GRANT until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      ptr_r        <= {PTR_W{1'b0}};
      gnt_idx_r    <= {PTR_W{1'b0}};
      gnt_valid_r  <= 1'b0;
      gnt_onehot_r <= {N{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_any_s) begin
            gnt_idx_r    <= pick_idx_s;
            gnt_onehot_r <= onehot_f(pick_idx_s);
            gnt_valid_r  <= 1'b1;
            state_r      <= GRANT;
          end else begin
            gnt_valid_r  <= 1'b0;
            gnt_onehot_r <= {N{1'b0}};
          end
        end
        GRANT: begin
          if (accept_s) begin
            if (gnt_idx_r == PTR_W'(N-1)) begin
              ptr_r <= {PTR_W{1'b0}};
            end else begin
              ptr_r <= gnt_idx_r + PTR_W'(1);
            end
            gnt_valid_r  <= 1'b0;
            gnt_onehot_r <= {N{1'b0}};
            state_r      <= IDLE;
          end else begin
            state_r <= GRANT;
          end
        end
        default: begin
          gnt_valid_r  <= 1'b0;
          gnt_onehot_r <= {N{1'b0}};
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt_valid  = gnt_valid_r;
  assign bus.gnt_onehot = gnt_onehot_r;
  assign bus.pending    = pending_r;

endmodule

// Grant-cleanliness checker for req_onehot_rr_arbiter outputs.
module req_onehot_rr_arbiter_chk #(
  parameter int N = 8
) (
  input logic         clk,
  input logic         rst_n,
  input logic         gnt_valid,
  input logic [N-1:0] gnt_onehot
);
  a_onehot_when_valid: assert property (@(posedge clk) disable iff (!rst_n)
    gnt_valid |-> $onehot(gnt_onehot))
    else $error("grant not one-hot while valid");

  a_zero_when_idle: assert property (@(posedge clk) disable iff (!rst_n)
    !gnt_valid |-> (gnt_onehot == {N{1'b0}}))
    else $error("grant nonzero while not valid");
endmodule
